// File: rtl/alu_wb_pkg.sv
// rtl/alu_wb_pkg.sv - opcodes, flag bit indices and opcode classification for the ALU writeback stage
package alu_wb_pkg;

  localparam logic [5:0] OP_ADD = 6'b001001;
  localparam logic [5:0] OP_ADC = 6'b001010;
  localparam logic [5:0] OP_SUB = 6'b001011;
  localparam logic [5:0] OP_SBB = 6'b001100;
  localparam logic [5:0] OP_AND = 6'b001101;
  localparam logic [5:0] OP_OR  = 6'b001110;
  localparam logic [5:0] OP_XOR = 6'b001111;
  localparam logic [5:0] OP_NOT = 6'b010000;
  localparam logic [5:0] OP_SHL = 6'b010001;
  localparam logic [5:0] OP_SHR = 6'b010010;
  localparam logic [5:0] OP_SAR = 6'b010011;
  localparam logic [5:0] OP_ROL = 6'b010100;
  localparam logic [5:0] OP_ROR = 6'b010101;
  localparam logic [5:0] OP_MOV = 6'b010110;
  localparam logic [5:0] OP_CMP = 6'b010111;
  localparam logic [5:0] OP_NEG = 6'b011000;
  localparam logic [5:0] OP_INC = 6'b011001;
  localparam logic [5:0] OP_DEC = 6'b011010;

  localparam int FLAG_ZF = 0;
  localparam int FLAG_CF = 1;
  localparam int FLAG_NF = 2;
  localparam int FLAG_OF = 3;

  typedef enum logic [1:0] {
    CLS_WRITE,
    CLS_FLAGONLY,
    CLS_ILLEGAL
  } op_class_e;

  // CMP only touches flags; everything else in the ALU range writes a register.
  function automatic op_class_e classify(input logic [5:0] op);
    if (op == OP_CMP) begin
      return CLS_FLAGONLY;
    end else if ((op >= OP_ADD) && (op <= OP_DEC)) begin
      return CLS_WRITE;
    end else begin
      return CLS_ILLEGAL;
    end
  endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// rtl/alu_wb_fifo.sv - in-order writeback buffer, head presented straight from storage
module alu_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [WIDTH-1:0] m_tdata
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign s_tready = !full;
  assign m_tvalid = !empty;
  assign push     = s_tvalid && !full;
  assign pop      = m_tready && !empty;

  // Stale storage is masked so an empty buffer always presents zeros.
  assign m_tdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer advance; pointers wrap naturally through the extra MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Entry storage needs no reset; the empty mask hides its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_tdata;
  end

endmodule

// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - ALU writeback/status stage; ALU_WB_STICKY_OF_EN makes OF sticky until of_clr
module alu_wb_stage
  import alu_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int REG_AW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [15:0]       in_result,
  input  logic              in_zf,
  input  logic              in_cf,
  input  logic              in_nf,
  input  logic              in_of,
  input  logic [REG_AW-1:0] in_rd,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_addr,
  output logic [15:0]       wb_data,
  output logic [3:0]        flags,
  output logic [15:0]       retire_cnt,
  input  logic              of_clr
);

  localparam int DW = REG_AW + 16;

  op_class_e        cls;
  logic             accept;
  logic             push;
  logic             flag_upd;
  logic [DW-1:0]    head;

  assign cls      = classify(in_opcode);
  assign accept   = in_valid && in_ready;
  assign push     = accept && (cls == CLS_WRITE);
  assign flag_upd = accept && (cls != CLS_ILLEGAL);

  alu_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tvalid (push),
    .s_tready (in_ready),
    .s_tdata  ({in_rd, in_result}),
    .m_tvalid (wb_valid),
    .m_tready (wb_ready),
    .m_tdata  (head)
  );

  assign wb_addr = head[DW-1:16];
  assign wb_data = head[15:0];

  // Lower flags always track the most recently accepted flag-producing instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags[FLAG_NF:FLAG_ZF] <= 3'b000;
    end else if (flag_upd) begin
      flags[FLAG_NF:FLAG_ZF] <= {in_nf, in_cf, in_zf};
    end
  end

`ifdef ALU_WB_STICKY_OF_EN
  // Sticky OF: a setting accept beats a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags[FLAG_OF] <= 1'b0;
    end else if (flag_upd && in_of) begin
      flags[FLAG_OF] <= 1'b1;
    end else if (of_clr) begin
      flags[FLAG_OF] <= 1'b0;
    end
  end
`else
  logic unused_of_clr;
  assign unused_of_clr = of_clr;

  // OF behaves like the other flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags[FLAG_OF] <= 1'b0;
    end else if (flag_upd) begin
      flags[FLAG_OF] <= in_of;
    end
  end
`endif

  // Count completed register-file writes; wraps at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= 16'h0000;
    end else if (wb_valid && wb_ready) begin
      retire_cnt <= retire_cnt + 16'h0001;
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// tb/tb_alu_wb_stage.sv - self-checking bench for alu_wb_stage (table, directed, random vs queue model)
module tb_alu_wb_stage;

  localparam int DEPTH = 4;
`ifdef ALU_WB_STICKY_OF_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_opcode = '0;
  logic [15:0] in_result = '0;
  logic        in_zf = 1'b0, in_cf = 1'b0, in_nf = 1'b0, in_of = 1'b0;
  logic [2:0]  in_rd = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [3:0]  flags;
  logic [15:0] retire_cnt;
  logic        of_clr = 1'b0;

  always #5 clk = ~clk;

  alu_wb_stage #(.FIFO_DEPTH(DEPTH), .REG_AW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_result  (in_result),
    .in_zf      (in_zf),
    .in_cf      (in_cf),
    .in_nf      (in_nf),
    .in_of      (in_of),
    .in_rd      (in_rd),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .flags      (flags),
    .retire_cnt (retire_cnt),
    .of_clr     (of_clr)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: pending register writes as a queue of {rd, data}.
  logic [18:0] mq[$];
  logic [3:0]  mflags;
  logic [15:0] mcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = register write, 1 = flags only, 2 = illegal
  function automatic int op_kind(input logic [5:0] op);
    if (op == 6'd23) return 1;
    if (op >= 6'd9 && op <= 6'd26) return 0;
    return 2;
  endfunction

  task automatic model_clear();
    mq.delete();
    mflags = 4'b0000;
    mcnt = 16'h0000;
  endtask

  // One clock: drive inputs, check outputs at the falling edge, advance the model at the rising edge.
  task automatic step(input logic v, input logic [5:0] op, input logic [15:0] res,
                      input logic [3:0] fl, input logic [2:0] rd, input logic wbr,
                      input logic ofc, input bit cmp);
    bit acc;
    int kind;
    in_valid = v; in_opcode = op; in_result = res; in_rd = rd;
    in_zf = fl[0]; in_cf = fl[1]; in_nf = fl[2]; in_of = fl[3];
    wb_ready = wbr; of_clr = ofc;
    @(negedge clk);
    if (cmp) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, (mq.size() < DEPTH)});
      chk("wb_valid", {31'b0, wb_valid}, {31'b0, (mq.size() != 0)});
      if (mq.size() != 0) begin
        chk("wb_addr", {29'b0, wb_addr}, {29'b0, mq[0][18:16]});
        chk("wb_data", {16'b0, wb_data}, {16'b0, mq[0][15:0]});
      end
      chk("flags", {28'b0, flags}, {28'b0, mflags});
      chk("retire_cnt", {16'b0, retire_cnt}, {16'b0, mcnt});
    end
    acc = v && (mq.size() < DEPTH);
    kind = op_kind(op);
    if (wbr && mq.size() != 0) begin
      void'(mq.pop_front());
      mcnt = mcnt + 16'd1;
    end
    if (acc && kind == 0) mq.push_back({rd, res});
    if (acc && kind != 2) mflags[2:0] = fl[2:0];
    if (STICKY) begin
      if (acc && kind != 2 && fl[3]) mflags[3] = 1'b1;
      else if (ofc) mflags[3] = 1'b0;
    end else if (acc && kind != 2) begin
      mflags[3] = fl[3];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic wbr);
    step(1'b0, 6'd0, 16'h0, 4'h0, 3'd0, wbr, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; wb_ready = 1'b0; of_clr = 1'b0;
    #1;
    model_clear();
    chk("rst wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst wb_addr", {29'b0, wb_addr}, 32'd0);
    chk("rst wb_data", {16'b0, wb_data}, 32'd0);
    chk("rst flags", {28'b0, flags}, 32'd0);
    chk("rst retire_cnt", {16'b0, retire_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [15:0] res;
    logic [3:0]  fl;
    logic [2:0]  rd;
    logic        exp_wb;
    logic [3:0]  exp_flags;
    logic [15:0] exp_retire;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [5:0] rop;
    int r;

    vecs[0] = '{6'b001001, 16'h0013, 4'b0000, 3'd2, 1'b1, 4'b0000, 16'd1};
    vecs[1] = '{6'b010111, 16'h0001, 4'b0010, 3'd5, 1'b0, 4'b0010, 16'd1};
    vecs[2] = '{6'b000000, 16'h1234, 4'b0001, 3'd1, 1'b0, 4'b0010, 16'd1};
    vecs[3] = '{6'b011010, 16'hFFFF, 4'b0100, 3'd7, 1'b1, 4'b0100, 16'd2};
    vecs[4] = '{6'b011011, 16'h5555, 4'b1111, 3'd6, 1'b0, 4'b0100, 16'd2};
    vecs[5] = '{6'b001000, 16'hAAAA, 4'b0111, 3'd4, 1'b0, 4'b0100, 16'd2};
    vecs[6] = '{6'b010110, 16'hBEEF, 4'b1001, 3'd3, 1'b1, 4'b1001, 16'd3};

    do_reset();

    // Table: one instruction, check the following cycle, then drain one cycle.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, vecs[i].op, vecs[i].res, vecs[i].fl, vecs[i].rd, 1'b1, 1'b0, 1'b1);
      chk($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, 32'd1);
      chk($sformatf("vec%0d wb_valid", i), {31'b0, wb_valid}, {31'b0, vecs[i].exp_wb});
      if (vecs[i].exp_wb) begin
        chk($sformatf("vec%0d wb_addr", i), {29'b0, wb_addr}, {29'b0, vecs[i].rd});
        chk($sformatf("vec%0d wb_data", i), {16'b0, wb_data}, {16'b0, vecs[i].res});
      end
      chk($sformatf("vec%0d flags", i), {28'b0, flags}, {28'b0, vecs[i].exp_flags});
      idle(1'b1);
      chk($sformatf("vec%0d retire", i), {16'b0, retire_cnt}, {16'b0, vecs[i].exp_retire});
    end

    // Backpressure: fill the buffer, then drain in order.
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1'b1, 6'b001001, 16'hA000 + 16'(i), 4'b0000, 3'(i), 1'b0, 1'b0, 1'b1);
    chk("full in_ready", {31'b0, in_ready}, 32'd0);
    step(1'b1, 6'b001001, 16'hDEAD, 4'b0000, 3'd7, 1'b0, 1'b0, 1'b1);
    chk("full hold data", {16'b0, wb_data}, 32'h0000A000);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d addr", i), {29'b0, wb_addr}, i);
      chk($sformatf("drain%0d data", i), {16'b0, wb_data}, 32'h0000A000 + i);
      idle(1'b1);
    end
    chk("drain retire", {16'b0, retire_cnt}, 32'd4);
    chk("drain wb_valid", {31'b0, wb_valid}, 32'd0);

    // OF behaviour: sticky only when the optional feature is built in.
    step(1'b1, 6'b010111, 16'h0, 4'b1000, 3'd0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 6'b010111, 16'h0, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b1);
    chk("of after clear-of accept", {31'b0, flags[3]}, {31'b0, STICKY});
    step(1'b0, 6'b010111, 16'h0, 4'b0000, 3'd0, 1'b1, 1'b1, 1'b1);
    chk("of after of_clr", {31'b0, flags[3]}, 32'd0);
    step(1'b1, 6'b010111, 16'h0, 4'b1000, 3'd0, 1'b1, 1'b1, 1'b1);
    chk("of set beats clr", {31'b0, flags[3]}, 32'd1);

    // Random traffic against the queue model.
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      rop = 6'(9 + $urandom_range(0, 17));
      else if (r < 8) rop = 6'b010111;
      else            rop = 6'($urandom_range(0, 63));
      step(1'($urandom_range(0, 9) < 7), rop, 16'($urandom), 4'($urandom), 3'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 1'b1);
    end
    for (int n = 0; n < DEPTH + 1; n++) idle(1'b1);

    // retire_cnt wrap: stream writes until the counter reaches FFFF.
    do_reset();
    while (mcnt != 16'hFFFF)
      step(1'b1, 6'b001001, 16'h0042, 4'b0000, 3'd1, 1'b1, 1'b0, 1'b0);
    chk("retire at ffff", {16'b0, retire_cnt}, 32'h0000FFFF);
    idle(1'b1);
    chk("retire wrap", {16'b0, retire_cnt}, 32'd0);

    // Reset with two entries queued.
    step(1'b1, 6'b001011, 16'h1111, 4'b0110, 3'd3, 1'b0, 1'b0, 1'b1);
    step(1'b1, 6'b001011, 16'h2222, 4'b0110, 3'd4, 1'b0, 1'b0, 1'b1);
    chk("pre-reset wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("pre-reset flags", {28'b0, flags}, 32'h6);
    do_reset();
    idle(1'b1);
    chk("post-reset wb_valid", {31'b0, wb_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
